// File: rtl/rot_req_arbiter.sv
// Two-port round-robin arbiter that owns an 8-bit rotate-left register: accepts one
// {data, amt} command at a time, rotates it by amt one bit per cycle, returns the result.
module rot_req_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic             id_q, id_d;

    logic             grant0, grant1;
    logic             sel;
    logic [WIDTH-1:0] data_sel;
    logic [AMT_W-1:0] amt_sel;

    // A lone valid wins outright; a tie goes to the favoured requester.
    assign grant0 = req0_valid & (~req1_valid | ~prio_q);
    assign grant1 = req1_valid & (~req0_valid | prio_q);

    // Gated by rstn so nothing can be accepted while reset is held.
    assign req0_ready = rstn & (state_q == StIdle) & grant0;
    assign req1_ready = rstn & (state_q == StIdle) & grant1;

    assign sel      = req1_ready;
    assign data_sel = sel ? req1_data : req0_data;
    assign amt_sel  = sel ? req1_amt : req0_amt;

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        id_d    = id_q;
        unique case (state_q)
            StIdle: begin
                if (req0_ready | req1_ready) begin
                    reg_d   = data_sel;
                    cnt_d   = amt_sel;
                    id_d    = sel;
                    prio_d  = ~sel;
                    state_d = (amt_sel != '0) ? StShift : StResp;
                end
            end
            StShift: begin
                reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            reg_q   <= '0;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
        end
    end

    // reg_q only moves on accept or in SHIFT, so the result is stable throughout RESP.
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = reg_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rot_req_arbiter.sv
// Scoreboard bench for rot_req_arbiter: directed scenarios then random traffic, with
// a countdown reference model and an independent response monitor.
module tb_rot_req_arbiter;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk;
    logic             rstn;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic [AMT_W-1:0] req0_amt, req1_amt;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0] rsp_data;

    rot_req_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       id;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: 0 idle, 1 rotating with m_rem cycles left, 2 holding a result.
    int   m_mode = 0;
    int   m_rem  = 0;
    int   m_prio = 0;
    bit   just_reset = 0;
    bit   acc0, acc1;
    bit   seen_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rol(input logic [7:0] d, input int a);
        int s;
        int v;
        s = a % WIDTH;
        v = ((int'(d) << s) | (int'(d) >> (WIDTH - s))) & 8'hFF;
        return 8'(v);
    endfunction

    // Evaluated just before each rising edge with the inputs that edge will see.
    task automatic model_eval();
        bit e0, e1;
        int g;
        exp_t e;
        acc0 = 0;
        acc1 = 0;
        e0   = 0;
        e1   = 0;
        if (just_reset) begin
            chk("rst_rsp_data", int'(rsp_data), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            just_reset = 0;
        end
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("rsp_valid", int'(rsp_valid), int'(m_mode == 2));
        if (!rstn) begin
            chk("req0_ready_rst", int'(req0_ready), 0);
            chk("req1_ready_rst", int'(req1_ready), 0);
            m_mode = 0;
            m_prio = 0;
            q.delete();
            just_reset = 1;
            return;
        end
        case (m_mode)
            0: begin
                if (req0_valid && req1_valid) g = m_prio;
                else if (req0_valid)         g = 0;
                else if (req1_valid)         g = 1;
                else                         g = -1;
                e0 = (g == 0);
                e1 = (g == 1);
                if (g >= 0) begin
                    e.data = rol(g == 0 ? req0_data : req1_data,
                                 g == 0 ? int'(req0_amt) : int'(req1_amt));
                    e.id   = (g == 1);
                    m_rem  = (g == 0) ? int'(req0_amt) : int'(req1_amt);
                    e.cyc  = cyc + 1 + m_rem;
                    q.push_back(e);
                    m_prio = 1 - g;
                    m_mode = (m_rem == 0) ? 2 : 1;
                    acc0   = e0;
                    acc1   = e1;
                end
            end
            1: begin
                m_rem--;
                if (m_rem == 0) m_mode = 2;
            end
            default: if (rsp_ready) m_mode = 0;
        endcase
        chk("req0_ready", int'(req0_ready), int'(e0));
        chk("req1_ready", int'(req1_ready), int'(e1));
    endtask

    // Monitor: every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rstn) begin
            seen_valid = 0;
        end else if (rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", int'(rsp_valid), 0);
            end else begin
                if (!seen_valid) chk("rsp_latency", cyc, q[0].cyc);
                chk("rsp_data", int'(rsp_data), int'(q[0].data));
                chk("rsp_id", int'(rsp_id), int'(q[0].id));
                if (rsp_ready) begin
                    void'(q.pop_front());
                    seen_valid = 0;
                end else begin
                    seen_valid = 1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_mode != 0 || q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", n, 0);
    endtask

    task automatic run_req(input int p, input logic [7:0] d, input logic [2:0] a);
        int n;
        n = 0;
        if (p == 0) begin
            req0_valid = 1; req0_data = d; req0_amt = a;
        end else begin
            req1_valid = 1; req1_data = d; req1_amt = a;
        end
        do begin
            tick();
            n++;
        end while (!(p == 0 ? acc0 : acc1) && n < 50);
        if (n >= 50) chk("accept_timeout", n, 0);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic do_reset(input int n);
        rstn = 0;
        repeat (n) tick();
        rstn = 1;
    endtask

    task automatic contend();
        int  n;
        bit  got0, got1;
        got0 = 0;
        got1 = 0;
        n    = 0;
        req0_valid = 1; req0_data = 8'h01; req0_amt = 3'd2;
        req1_valid = 1; req1_data = 8'h10; req1_amt = 3'd3;
        while (!(got0 && got1) && n < 100) begin
            tick();
            n++;
            if (acc0) begin got0 = 1; req0_valid = 0; end
            if (acc1) begin got1 = 1; req1_valid = 0; end
        end
        if (n >= 100) chk("contend_timeout", n, 0);
        wait_idle();
    endtask

    initial begin
        rstn = 0; rsp_ready = 1;
        req0_valid = 0; req0_data = '0; req0_amt = '0;
        req1_valid = 0; req1_data = '0; req1_amt = '0;

        do_reset(2);
        tick();
        run_req(0, 8'h81, 3'd1);
        wait_idle();
        run_req(1, 8'hA5, 3'd0);
        wait_idle();
        run_req(0, 8'h01, 3'd7);
        wait_idle();

        // Both requesters pending out of reset, then a second tie.
        req0_valid = 1; req1_valid = 1;
        do_reset(2);
        contend();
        contend();

        // Backpressure held for several cycles in RESP.
        rsp_ready = 0;
        run_req(1, 8'h3C, 3'd2);
        repeat (8) tick();
        rsp_ready = 1;
        wait_idle();

        // Reset on the third rotate cycle: the result must vanish.
        run_req(0, 8'hFF, 3'd6);
        tick();
        tick();
        rstn = 0;
        tick();
        rstn = 1;
        repeat (15) tick();

        // Requester 1 pulses valid only while the block is rotating.
        run_req(0, 8'h5A, 3'd5);
        tick();
        req1_valid = 1; req1_data = 8'hC3; req1_amt = 3'd1;
        tick();
        req1_valid = 0;
        wait_idle();
        repeat (10) tick();

        for (int c = 0; c < 3000; c++) begin
            if (acc0 || (req0_valid && $urandom_range(7) == 0)) req0_valid = 0;
            if (!req0_valid && $urandom_range(2) == 0) begin
                req0_valid = 1; req0_data = 8'($urandom); req0_amt = 3'($urandom);
            end
            if (acc1 || (req1_valid && $urandom_range(7) == 0)) req1_valid = 0;
            if (!req1_valid && $urandom_range(2) == 0) begin
                req1_valid = 1; req1_data = 8'($urandom); req1_amt = 3'($urandom);
            end
            rsp_ready = ($urandom_range(9) < 7);
            tick();
        end
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        wait_idle();
        tick();
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
